seg_display_driver: RTL

Downstream display stage for the SPI sensor readout. It accepts one signed sample at a time from the SPI master's capture logic and converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes sign plus three decimal digits onto a 4-digit common-anode seven-segment display, and drives three axis-indicator outputs. A sample that arrives during a conversion is buffered in a one-entry pending slot.

---
 rtl/seg_display_if.sv | 17 +
 rtl/seg_display_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_if.sv
// Sample-in / display-out bundle between the SPI capture logic and the display driver.
interface seg_display_if #(
    parameter int DATA_W = 10
) ();
    logic              load;
    logic [DATA_W-1:0] data;
    logic [1:0]        axis;
    logic              busy;
    logic [6:0]        seg;
    logic [3:0]        an;
    logic              dp0;
    logic              dp2;
    logic              dp4;

    modport master (output load, data, axis, input busy, seg, an, dp0, dp2, dp4);
    modport slave  (input load, data, axis, output busy, seg, an, dp0, dp2, dp4);
endinterface

// File: rtl/seg_display_driver.sv
// Signed sample -> BCD (sequential double-dabble) -> 4-digit multiplexed 7-seg with axis LEDs.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module seg_display_driver #(
    parameter int DATA_W      = 10,
    parameter int REFRESH_DIV = 100000
) (
    input  logic          clk,
    input  logic          rst,
    seg_display_if.slave  bus
);
    localparam int CW = $clog2(DATA_W);
    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_bit;
    logic [DATA_W-1:0] r_mag;
    logic [11:0]       r_bcd;
    logic              r_sign;
    logic [1:0]        r_axis;
    logic              r_busy;
    logic              r_pend_vld;
    logic [DATA_W-1:0] r_pend_data;
    logic [1:0]        r_pend_axis;
    logic [11:0]       r_disp_bcd;
    logic              r_disp_sign;
    logic              r_dp0, r_dp2, r_dp4;
    logic [RW-1:0]     r_cnt;
    logic [1:0]        r_idx;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;

    logic [11:0]        w_adj;
    logic [11+DATA_W:0] w_shift;
    logic               w_start;
    logic [DATA_W-1:0]  w_src_data;
    logic [1:0]         w_src_axis;
    logic [DATA_W-1:0]  w_src_mag;
    logic               w_blank_h;
    logic               w_blank_t;
    logic [6:0]         w_digit;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'b1000000;
            4'd1:    enc7 = 7'b1111001;
            4'd2:    enc7 = 7'b0100100;
            4'd3:    enc7 = 7'b0110000;
            4'd4:    enc7 = 7'b0011001;
            4'd5:    enc7 = 7'b0010010;
            4'd6:    enc7 = 7'b0000010;
            4'd7:    enc7 = 7'b1111000;
            4'd8:    enc7 = 7'b0000000;
            4'd9:    enc7 = 7'b0010000;
            default: enc7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++)
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end

    assign w_shift = {w_adj, r_mag} << 1;

    // A load arriving in COMMIT takes priority over the older pending sample (latest wins).
    always_comb begin
        w_start    = 1'b0;
        w_src_data = bus.data;
        w_src_axis = bus.axis;
        case (r_state)
            S_IDLE:   w_start = bus.load;
            S_COMMIT: begin
                w_start = bus.load | r_pend_vld;
                if (!bus.load) begin
                    w_src_data = r_pend_data;
                    w_src_axis = r_pend_axis;
                end
            end
            default:  w_start = 1'b0;
        endcase
        w_src_mag = w_src_data[DATA_W-1] ? (~w_src_data + DATA_W'(1)) : w_src_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit       <= '0;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_sign      <= 1'b0;
            r_axis      <= 2'd3;
            r_busy      <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_pend_axis <= 2'd3;
            r_disp_bcd  <= '0;
            r_disp_sign <= 1'b0;
            r_dp0       <= 1'b0;
            r_dp2       <= 1'b0;
            r_dp4       <= 1'b0;
        end else begin
            case (r_state)
                S_CONVERT: begin
                    r_bcd <= w_shift[11+DATA_W:DATA_W];
                    r_mag <= w_shift[DATA_W-1:0];
                    r_bit <= r_bit + CW'(1);
                    if (r_bit == CW'(DATA_W-1)) r_state <= S_COMMIT;
                    if (bus.load) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_data <= bus.data;
                        r_pend_axis <= bus.axis;
                    end
                end
                S_COMMIT: begin
                    r_disp_bcd  <= r_bcd;
                    r_disp_sign <= r_sign;
                    r_dp0       <= (r_axis == 2'd0);
                    r_dp2       <= (r_axis == 2'd1);
                    r_dp4       <= (r_axis == 2'd2);
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
            if (w_start) begin
                r_sign     <= w_src_data[DATA_W-1];
                r_mag      <= w_src_mag;
                r_axis     <= w_src_axis;
                r_bcd      <= '0;
                r_bit      <= '0;
                r_pend_vld <= 1'b0;
                r_state    <= S_CONVERT;
                r_busy     <= 1'b1;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign w_blank_h = (r_disp_bcd[11:8] == 4'd0);
    assign w_blank_t = w_blank_h && (r_disp_bcd[7:4] == 4'd0);
`else
    assign w_blank_h = 1'b0;
    assign w_blank_t = 1'b0;
`endif

    always_comb begin
        w_digit = 7'h7F;
        case (r_idx)
            2'd0: w_digit = enc7(r_disp_bcd[3:0]);
            2'd1: w_digit = w_blank_t ? 7'h7F : enc7(r_disp_bcd[7:4]);
            2'd2: w_digit = w_blank_h ? 7'h7F : enc7(r_disp_bcd[11:8]);
            2'd3: w_digit = (r_disp_sign && (r_disp_bcd != 12'd0)) ? 7'b0111111 : 7'h7F;
            default: w_digit = 7'h7F;
        endcase
    end

    // an and seg load together on the wrap edge so a digit never shows another digit's segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_seg <= 7'h7F;
            r_an  <= 4'hF;
        end else if (r_cnt == RW'(REFRESH_DIV-1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
            r_seg <= w_digit;
            r_an  <= ~(4'b0001 << r_idx);
        end else begin
            r_cnt <= r_cnt + RW'(1);
        end
    end

    assign bus.busy = r_busy;
    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.dp0  = r_dp0;
    assign bus.dp2  = r_dp2;
    assign bus.dp4  = r_dp4;
endmodule
